// File: rtl/commutation_monitor_if.sv
// Switch-word / status bundle between the commutation controller side and commutation_monitor.
// COMM_MON_COUNT_EN adds the per-channel commutation event counters (comm_count).
interface commutation_monitor_if #(
    parameter int unsigned CNT_W = 16
);
    logic [17:0] Sout;
    logic        fault_clr;
    logic [5:0]  LoadOut;
    logic [2:0]  stable;
    logic [2:0]  comm_done;
    logic [2:0]  fault;
    logic [5:0]  fault_code;
    logic        short;
`ifdef COMM_MON_COUNT_EN
    logic [3*CNT_W-1:0] comm_count;

    modport master (
        output Sout, fault_clr,
        input  LoadOut, stable, comm_done, fault, fault_code, short, comm_count
    );
    modport slave (
        input  Sout, fault_clr,
        output LoadOut, stable, comm_done, fault, fault_code, short, comm_count
    );
`else
    modport master (
        output Sout, fault_clr,
        input  LoadOut, stable, comm_done, fault, fault_code, short
    );
    modport slave (
        input  Sout, fault_clr,
        output LoadOut, stable, comm_done, fault, fault_code, short
    );
`endif
endinterface

// File: rtl/commutation_monitor.sv
// Decodes the 18-bit matrix-converter switch word per channel, times commutations and flags
// shoot-through / stuck commutation. COMM_MON_COUNT_EN adds saturating comm_done counters.
module commutation_monitor #(
    parameter int unsigned MAX_COMM_CYC = 8,
    parameter int unsigned CNT_W        = 16
) (
    input logic                  clk,
    input logic                  rst,
    commutation_monitor_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StStbl, StTrans, StFault} state_e;
    typedef enum logic [1:0] {PatNull, PatStable, PatTrans, PatIllegal} pat_e;

    localparam int unsigned       TcntW   = $clog2(MAX_COMM_CYC + 1);
    localparam logic [TcntW-1:0]  TcntMax = TcntW'(MAX_COMM_CYC);
    localparam logic [TcntW-1:0]  TcntOne = TcntW'(1);

    if (MAX_COMM_CYC < 2 || CNT_W < 1) begin : g_bad_param
        $error("commutation_monitor: MAX_COMM_CYC must be >= 2 and CNT_W >= 1");
    end

    // Pair k occupies w[5-2k -: 2]; k=0 is phase A.
    function automatic pat_e classify(input logic [5:0] w);
        logic [2:0] on;
        logic [2:0] nz;
        for (int k = 0; k < 3; k++) begin
            on[k] = &w[5-2*k -: 2];
            nz[k] = |w[5-2*k -: 2];
        end
        if (nz == 3'b000) return PatNull;
        if (on == 3'b000) return PatTrans;
        if (((on & (on - 3'd1)) == 3'b000) && ((nz & ~on) == 3'b000)) return PatStable;
        return PatIllegal;
    endfunction

    function automatic logic [1:0] load_code(input logic [5:0] w);
        if (&w[5:4]) return 2'b01;
        if (&w[3:2]) return 2'b10;
        if (&w[1:0]) return 2'b11;
        return 2'b00;
    endfunction

    state_e           state_q [3];
    state_e           state_d [3];
    logic [TcntW-1:0] tcnt_q  [3];
    logic [TcntW-1:0] tcnt_d  [3];
    logic [1:0]       load_q  [3];
    logic [1:0]       load_d  [3];
    logic [1:0]       code_q  [3];
    logic [1:0]       code_d  [3];
    logic [2:0]       stable_q, stable_d;
    logic [2:0]       done_q, done_d;
    logic [2:0]       fault_q, fault_d;
    logic             short_q, short_d;

    always_comb begin
        pat_e       pat;
        logic [5:0] w;
        logic [1:0] lc;
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        load_d   = load_q;
        code_d   = code_q;
        stable_d = stable_q;
        done_d   = 3'b000;
        fault_d  = fault_q;
        for (int n = 0; n < 3; n++) begin
            w   = bus.Sout[17-6*n -: 6];
            pat = classify(w);
            lc  = load_code(w);
            case (state_q[n])
                StFault: begin
                    // Only a clear against a fully-off channel releases it; stored code is kept
                    // against any later ILLEGAL pattern.
                    if (bus.fault_clr && (pat == PatNull)) begin
                        state_d[n]    = StIdle;
                        fault_d[2-n]  = 1'b0;
                        code_d[n]     = 2'b00;
                        stable_d[2-n] = 1'b1;
                    end else begin
                        stable_d[2-n] = 1'b0;
                    end
                end
                default: begin
                    if (pat == PatIllegal) begin
                        state_d[n]    = StFault;
                        fault_d[2-n]  = 1'b1;
                        code_d[n]     = 2'b01;
                        stable_d[2-n] = 1'b0;
                        tcnt_d[n]     = '0;
                    end else if (pat == PatTrans) begin
                        stable_d[2-n] = 1'b0;
                        if (state_q[n] != StTrans) begin
                            state_d[n] = StTrans;
                            tcnt_d[n]  = TcntOne;
                        end else if ((tcnt_q[n] + TcntOne) >= TcntMax) begin
                            state_d[n]   = StFault;
                            fault_d[2-n] = 1'b1;
                            code_d[n]    = 2'b10;
                            tcnt_d[n]    = '0;
                        end else begin
                            tcnt_d[n] = tcnt_q[n] + TcntOne;
                        end
                    end else begin
                        state_d[n]    = (pat == PatNull) ? StIdle : StStbl;
                        tcnt_d[n]     = '0;
                        load_d[n]     = lc;
                        stable_d[2-n] = 1'b1;
                        done_d[2-n]   = (lc != load_q[n]);
                    end
                end
            endcase
        end
        short_d = |fault_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 3; n++) begin
                state_q[n] <= StIdle;
                tcnt_q[n]  <= '0;
                load_q[n]  <= 2'b00;
                code_q[n]  <= 2'b00;
            end
            stable_q <= 3'b111;
            done_q   <= 3'b000;
            fault_q  <= 3'b000;
            short_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            load_q   <= load_d;
            code_q   <= code_d;
            stable_q <= stable_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            short_q  <= short_d;
        end
    end

    assign bus.LoadOut    = {load_q[0], load_q[1], load_q[2]};
    assign bus.fault_code = {code_q[0], code_q[1], code_q[2]};
    assign bus.stable     = stable_q;
    assign bus.comm_done  = done_q;
    assign bus.fault      = fault_q;
    assign bus.short      = short_q;

`ifdef COMM_MON_COUNT_EN
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    always_comb begin
        cnt_d = cnt_q;
        for (int n = 0; n < 3; n++) begin
            if (done_d[2-n] && (cnt_q[n] != {CNT_W{1'b1}})) begin
                cnt_d[n] = cnt_q[n] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 3; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.comm_count = {cnt_q[0], cnt_q[1], cnt_q[2]};
`endif

endmodule
